// File: rtl/hazard_scheduler.sv
// hazard_scheduler: tracks E/M/W register writes, drives forwarding mux selects and stall.
// Optional MDU busy tracking is built when HAZARD_MDU_EN is defined.
module hazard_scheduler #(
   parameter int REG_W = 5,
   parameter int T_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_valid,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic [T_W-1:0]   d_rs_tuse,
   input  logic [T_W-1:0]   d_rt_tuse,
   input  logic [REG_W-1:0] d_dst,
   input  logic [T_W-1:0]   d_tnew,
   input  logic             d_md_use,
   input  logic             e_md_start,
   input  logic             e_md_div,
   output logic             stall,
   output logic [1:0]       fwd_d_rs,
   output logic [1:0]       fwd_d_rt,
   output logic [1:0]       fwd_e_rs,
   output logic [1:0]       fwd_e_rt,
   output logic             fwd_m_rt,
   output logic             md_busy
);
   logic             e_v, m_v, w_v, load, md_hz;
   logic [REG_W-1:0] e_dst, e_rs, e_rt, m_dst, m_rt, w_dst;
   logic [T_W-1:0]   e_tnew, m_tnew;

   function automatic logic hit(input logic v, input logic [REG_W-1:0] dst, input logic [REG_W-1:0] r);
      return v && dst != '0 && dst == r;
   endfunction

   function automatic logic [T_W-1:0] dec(input logic [T_W-1:0] t);
      return (t == '0) ? '0 : t - T_W'(1);
   endfunction

   function automatic logic hz(input logic [REG_W-1:0] r, input logic [T_W-1:0] tuse);
      return (hit(e_v, e_dst, r) && e_tnew > tuse) || (hit(m_v, m_dst, r) && m_tnew > tuse);
   endfunction

   // youngest matching slot decides; a not-yet-ready producer selects RF (only seen under stall)
   function automatic logic [1:0] fwd_d(input logic [REG_W-1:0] r);
      return hit(e_v, e_dst, r) ? ((e_tnew == '0) ? 2'd1 : 2'd0) :
             hit(m_v, m_dst, r) ? ((m_tnew == '0) ? 2'd2 : 2'd0) :
             hit(w_v, w_dst, r) ? 2'd3 : 2'd0;
   endfunction

   function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] r);
      return (hit(m_v, m_dst, r) && m_tnew == '0) ? 2'd1 : hit(w_v, w_dst, r) ? 2'd2 : 2'd0;
   endfunction

   assign stall    = d_valid && (hz(d_rs, d_rs_tuse) || hz(d_rt, d_rt_tuse) || md_hz);
   assign load     = d_valid && !stall;
   assign fwd_d_rs = fwd_d(d_rs);
   assign fwd_d_rt = fwd_d(d_rt);
   assign fwd_e_rs = fwd_e(e_rs);
   assign fwd_e_rt = fwd_e(e_rt);
   assign fwd_m_rt = hit(w_v, w_dst, m_rt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_v    <= 1'b0;
         e_dst  <= '0;
         e_rs   <= '0;
         e_rt   <= '0;
         e_tnew <= '0;
         m_v    <= 1'b0;
         m_dst  <= '0;
         m_rt   <= '0;
         m_tnew <= '0;
         w_v    <= 1'b0;
         w_dst  <= '0;
      end else begin
         w_v    <= m_v;
         w_dst  <= m_dst;
         m_v    <= e_v;
         m_dst  <= e_dst;
         m_rt   <= e_rt;
         m_tnew <= dec(e_tnew);
         e_v    <= load;
         e_dst  <= load ? d_dst : '0;
         e_rs   <= load ? d_rs : '0;
         e_rt   <= load ? d_rt : '0;
         e_tnew <= load ? d_tnew : '0;
      end
   end

`ifdef HAZARD_MDU_EN
   logic [3:0] cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else cnt <= e_md_start ? (e_md_div ? 4'd10 : 4'd5) : (cnt == '0) ? '0 : cnt - 4'd1;
   end
   assign md_busy = cnt != '0;
   assign md_hz   = d_md_use && (md_busy || e_md_start);
`else
   logic unused;
   assign unused  = ^{d_md_use, e_md_start, e_md_div};
   assign md_busy = 1'b0;
   assign md_hz   = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed hazard scenarios against an in-bench pipeline model.
module tb_hazard_scheduler;
   logic       clk = 1'b0;
   logic       reset, d_valid, d_md_use, e_md_start, e_md_div;
   logic [4:0] d_rs, d_rt, d_dst;
   logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
   logic       stall, fwd_m_rt, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
   int         checks = 0, errors = 0;
   int         ns, nb;

   // model: index 0=E, 1=M, 2=W; tnew stored as issued and aged by stage index
   logic       mv[3];
   logic [4:0] mdst[3], mrs[3], mrt[3];
   int         mtn[3];
   int         cyc = 0, md_end = 0;

   hazard_scheduler dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_dst(d_dst), .d_tnew(d_tnew),
      .d_md_use(d_md_use), .e_md_start(e_md_start), .e_md_div(e_md_div),
      .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
      .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   function automatic int tn(int k);
      return (mtn[k] - k > 0) ? mtn[k] - k : 0;
   endfunction

   function automatic bit mhit(int k, logic [4:0] r);
      return mv[k] && mdst[k] != 0 && mdst[k] == r;
   endfunction

   function automatic bit m_busy();
`ifdef HAZARD_MDU_EN
      return cyc < md_end;
`else
      return 0;
`endif
   endfunction

   function automatic bit exp_stall();
      bit s = 0;
      for (int k = 0; k < 2; k++) begin
         if (mhit(k, d_rs) && tn(k) > int'(d_rs_tuse)) s = 1;
         if (mhit(k, d_rt) && tn(k) > int'(d_rt_tuse)) s = 1;
      end
`ifdef HAZARD_MDU_EN
      if (d_md_use && (m_busy() || e_md_start)) s = 1;
`endif
      return d_valid && s;
   endfunction

   function automatic int exp_fd(logic [4:0] r);
      for (int k = 0; k < 3; k++)
         if (mhit(k, r)) return (k == 2 || tn(k) == 0) ? k + 1 : 0;
      return 0;
   endfunction

   function automatic int exp_fe(logic [4:0] r);
      if (mhit(1, r) && tn(1) == 0) return 1;
      if (mhit(2, r)) return 2;
      return 0;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            mv[k] <= 0; mdst[k] <= 0; mrs[k] <= 0; mrt[k] <= 0; mtn[k] <= 0;
         end
         md_end <= 0;
      end else begin
         if (e_md_start) md_end <= cyc + (e_md_div ? 10 : 5) + 1;
         for (int k = 2; k > 0; k--) begin
            mv[k] <= mv[k-1]; mdst[k] <= mdst[k-1]; mrs[k] <= mrs[k-1];
            mrt[k] <= mrt[k-1]; mtn[k] <= mtn[k-1];
         end
         if (d_valid && !exp_stall()) begin
            mv[0] <= 1; mdst[0] <= d_dst; mrs[0] <= d_rs; mrt[0] <= d_rt; mtn[0] <= int'(d_tnew);
         end else begin
            mv[0] <= 0; mdst[0] <= 0; mrs[0] <= 0; mrt[0] <= 0; mtn[0] <= 0;
         end
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      chk("m_stall", stall, exp_stall());
      chk("m_fwd_d_rs", fwd_d_rs, exp_fd(d_rs));
      chk("m_fwd_d_rt", fwd_d_rt, exp_fd(d_rt));
      chk("m_fwd_e_rs", fwd_e_rs, exp_fe(mrs[0]));
      chk("m_fwd_e_rt", fwd_e_rt, exp_fe(mrt[0]));
      chk("m_fwd_m_rt", fwd_m_rt, mhit(2, mrt[1]));
      chk("m_md_busy", md_busy, m_busy());
   end

   task automatic drive(input logic v, input logic [4:0] rs, rt, input logic [1:0] urs, urt,
                        input logic [4:0] dst, input logic [1:0] t);
      d_valid = v; d_rs = rs; d_rt = rt; d_rs_tuse = urs; d_rt_tuse = urt;
      d_dst = dst; d_tnew = t; d_md_use = 0;
   endtask

   task automatic idle();
      drive(0, 0, 0, 3, 3, 0, 0);
   endtask

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      idle(); repeat (3) adv();
   endtask

   initial begin
      reset = 1; e_md_start = 0; e_md_div = 0; idle();
      repeat (2) @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_fwd", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}, 0);
      chk("rst_md_busy", md_busy, 0);
      adv(); reset = 0;
      // load-use
      drive(1, 1, 0, 1, 3, 8, 2); @(negedge clk); chk("lw_nostall", stall, 0);
      adv(); drive(1, 8, 9, 1, 1, 10, 1); @(negedge clk); chk("lu_stall", stall, 1);
      adv(); @(negedge clk); chk("lu_release", stall, 0); chk("lu_fwd_d_rs", fwd_d_rs, 0);
      adv(); idle(); @(negedge clk); chk("lu_fwd_e_rs_w", fwd_e_rs, 2);
      drain();
      // invalid D never stalls
      drive(1, 0, 0, 3, 3, 8, 2); adv();
      drive(0, 8, 8, 0, 0, 0, 0); @(negedge clk); chk("bubble_nostall", stall, 0);
      adv(); drain();
      // ALU chain
      drive(1, 1, 2, 1, 1, 3, 1); adv();
      drive(1, 3, 3, 1, 1, 4, 1); @(negedge clk); chk("alu_nostall", stall, 0);
      adv(); idle(); @(negedge clk); chk("alu_fwd_e_rs", fwd_e_rs, 1); chk("alu_fwd_e_rt", fwd_e_rt, 1);
      drain();
      // branch on fresh ALU result
      drive(1, 1, 2, 1, 1, 5, 1); adv();
      drive(1, 5, 6, 0, 0, 0, 0); @(negedge clk); chk("br_stall", stall, 1);
      adv(); @(negedge clk); chk("br_release", stall, 0); chk("br_fwd_d_rs", fwd_d_rs, 2);
      adv(); drain();
      // register zero
      drive(1, 0, 0, 1, 1, 0, 2); adv();
      drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
      chk("r0_stall", stall, 0); chk("r0_fwd_d", {fwd_d_rs, fwd_d_rt}, 0);
      adv(); idle(); @(negedge clk); chk("r0_fwd_e", {fwd_e_rs, fwd_e_rt}, 0);
      drain();
      // store data forwarding through E then M
      drive(1, 1, 2, 1, 1, 7, 1); adv();
      drive(1, 0, 7, 3, 2, 0, 0); @(negedge clk); chk("st_nostall", stall, 0);
      adv(); idle(); @(negedge clk); chk("st_fwd_e_rt", fwd_e_rt, 1);
      adv(); @(negedge clk); chk("st_fwd_m_rt", fwd_m_rt, 1);
      drain();
      // W-stage forwarding to D
      drive(1, 1, 2, 1, 1, 13, 1); adv(); idle(); adv(); adv();
      drive(1, 13, 0, 0, 3, 0, 0); @(negedge clk); chk("w_fwd_d_rs", fwd_d_rs, 3);
      adv(); drain();
      // E beats M
      drive(1, 0, 0, 3, 3, 11, 0); adv(); adv();
      drive(1, 11, 0, 0, 3, 0, 0); @(negedge clk); chk("em_prio", fwd_d_rs, 1);
      adv(); drain();
      // M beats W
      drive(1, 0, 0, 3, 3, 12, 0); adv();
      drive(1, 0, 0, 3, 3, 12, 1); adv(); idle(); adv();
      drive(1, 12, 0, 0, 3, 0, 0); @(negedge clk); chk("mw_prio", fwd_d_rs, 2);
      adv(); drain();
      // reset mid-stall
      drive(1, 1, 2, 1, 1, 8, 2); adv();
      drive(1, 8, 0, 1, 3, 9, 1); @(negedge clk); chk("rs_stall", stall, 1);
      #1 reset = 1; #1 chk("rs_drop", stall, 0);
      adv(); reset = 0; @(negedge clk);
      chk("rs_after_stall", stall, 0); chk("rs_after_fwd", fwd_d_rs, 0);
      adv(); drain();
      // MDU divide then dependent mfhi
      drive(1, 0, 0, 3, 3, 2, 1); d_md_use = 1; e_md_start = 1; e_md_div = 1;
      ns = 0; nb = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); ns += int'(stall); nb += int'(md_busy);
         adv(); e_md_start = 0;
      end
      e_md_div = 0; drain();
`ifdef HAZARD_MDU_EN
      chk("md_stall_cycles", ns, 11); chk("md_busy_cycles", nb, 10);
`else
      chk("md_stall_cycles", ns, 0); chk("md_busy_cycles", nb, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
